kyber_core_arbiter: RTL

Round-robin arbiter and sequencer that shares one Kyber core among N requesters. The core runs keygen, encaps or decaps, and is driven by start/mode/finish. The arbiter accepts operation requests, validates the mode, and issues a single-cycle core_start with the granted mode. It holds the grant until the core reports finish, then returns a per-requester done pulse. grant_idx is exported so the data-bus muxes (pk/sk/c/m) outside this block can steer operands and results.

---
 rtl/kyber_pkg.sv | 20 ++
 rtl/rr_pick.sv | 37 +++
 rtl/kyber_core_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/kyber_pkg.sv
// Shared definitions for the Kyber core arbiter.
// Holds the mode encodings, the arbiter state type and the mode legality check.
package kyber_pkg;

  localparam logic [1:0] MODE_KEYGEN = 2'd0;
  localparam logic [1:0] MODE_ENCAPS = 2'd1;
  localparam logic [1:0] MODE_DECAPS = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  function automatic logic is_legal_mode(input logic [1:0] mode);
    return (mode == MODE_KEYGEN) || (mode == MODE_ENCAPS) || (mode == MODE_DECAPS);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder.
// Returns the first set bit of req at or above rr_ptr, wrapping past N_REQ-1.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0]    cand_idx [N_REQ];
  logic [N_REQ-1:0] hit;

  // Candidate gi is the requester gi positions after rr_ptr, modulo N_REQ.
  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum          = {1'b0, rr_ptr} + (IW+1)'(gi);
    assign cand_idx[gi] = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : sum[IW-1:0];
    assign hit[gi]      = req[cand_idx[gi]];
  end

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        valid = 1'b1;
        idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/kyber_core_arbiter.sv
// Round-robin arbiter/sequencer sharing one Kyber core among N_REQ requesters.
// Optional watchdog on the core completion enabled by defining KYBER_ARB_TIMEOUT_EN.
module kyber_core_arbiter
  import kyber_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       req_mode,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         err,
  output logic                     core_start,
  output logic [1:0]               core_mode,
  input  logic                     core_finish,
  output logic                     busy
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t       state_reg, state_next;
  logic [IW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]    grant_idx_reg, grant_idx_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic [N_REQ-1:0] done_reg, done_next;
  logic [N_REQ-1:0] err_reg, err_next;
  logic [1:0]       core_mode_reg, core_mode_next;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [1:0]       mode_arr [N_REQ];

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_mode
    assign mode_arr[gi] = req_mode[2*gi +: 2];
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(N_REQ - 1)) ? '0 : v + IW'(1);
  endfunction

`ifdef KYBER_ARB_TIMEOUT_EN
  logic [31:0] timer_reg, timer_next;
  logic        timer_expired;
  assign timer_expired = (timer_reg == 32'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_idx_next = grant_idx_reg;
    grant_next     = grant_reg;
    core_mode_next = core_mode_reg;
    done_next      = '0;
    err_next       = '0;
`ifdef KYBER_ARB_TIMEOUT_EN
    timer_next     = timer_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          if (is_legal_mode(mode_arr[pick_idx])) begin
            grant_next     = N_REQ'(1) << pick_idx;
            grant_idx_next = pick_idx;
            core_mode_next = mode_arr[pick_idx];
            state_next     = ST_ISSUE;
          end else begin
            // Reject without touching grant_idx so the data muxes stay put.
            err_next    = N_REQ'(1) << pick_idx;
            rr_ptr_next = wrap_inc(pick_idx);
          end
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
`ifdef KYBER_ARB_TIMEOUT_EN
        timer_next = '0;
`endif
      end
      ST_WAIT: begin
        if (core_finish) begin
          done_next  = N_REQ'(1) << grant_idx_reg;
          grant_next = '0;
          state_next = ST_RESP;
        end
`ifdef KYBER_ARB_TIMEOUT_EN
        else if (timer_expired) begin
          err_next    = N_REQ'(1) << grant_idx_reg;
          grant_next  = '0;
          rr_ptr_next = wrap_inc(grant_idx_reg);
          state_next  = ST_IDLE;
        end else begin
          timer_next = timer_reg + 32'd1;
        end
`endif
      end
      ST_RESP: begin
        rr_ptr_next = wrap_inc(grant_idx_reg);
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      grant_idx_reg <= '0;
      grant_reg     <= '0;
      done_reg      <= '0;
      err_reg       <= '0;
      core_mode_reg <= MODE_KEYGEN;
`ifdef KYBER_ARB_TIMEOUT_EN
      timer_reg     <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_idx_reg <= grant_idx_next;
      grant_reg     <= grant_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      core_mode_reg <= core_mode_next;
`ifdef KYBER_ARB_TIMEOUT_EN
      timer_reg     <= timer_next;
`endif
    end
  end

  assign grant      = grant_reg;
  assign grant_idx  = grant_idx_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign core_mode  = core_mode_reg;
  assign core_start = (state_reg == ST_ISSUE);
  assign busy       = (state_reg != ST_IDLE);

endmodule
